// File: rtl/serial_shift_pkg.sv
// Shared types and helpers for the serial shift unit: FSM state encoding,
// shift-direction constants and the shift-counter width calculation.
package serial_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=2.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ms_dff.sv
// Master-slave D flip-flop from two mux-feedback latches, with a clock
// enable folded into the master input and an asynchronous active-high reset.
module ms_dff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_master;
    logic r_slave;
    logic w_d_eff;

    // Recirculating the slave keeps the stored bit when disabled, and re-evaluates if en moves while the master is open.
    assign w_d_eff = i_en ? i_d : r_slave;

    always_latch begin
        if (i_rst)
            r_master <= 1'b0;
        else if (!i_clk)
            r_master <= w_d_eff;
    end

    always_latch begin
        if (i_rst)
            r_slave <= 1'b0;
        else if (i_clk)
            r_slave <= r_master;
    end

    assign o_q = r_slave;

endmodule

// File: rtl/serial_shift_unit.sv
// Universal shift register with parallel load and a controller that runs
// exactly WIDTH shifts per start, then pulses done for one enabled cycle.
module serial_shift_unit
    import serial_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;

    always_comb begin
        w_q_next = w_q;
        case (r_state)
            IDLE:    if (load) w_q_next = par_in;
            SHIFT:   w_q_next = (r_dir == DIR_RIGHT) ? {ser_in, w_q[WIDTH-1:1]}
                                                     : {w_q[WIDTH-2:0], ser_in};
            default: ;
        endcase
    end

    // Data storage: one latch-pair flip-flop per bit, frozen by en.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            ms_dff u_bit (
                .i_clk (clk),
                .i_rst (rst),
                .i_en  (en),
                .i_d   (w_q_next[g]),
                .o_q   (w_q[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_LEFT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (en) begin
            case (r_state)
                IDLE: begin
                    if (!load && start) begin
                        r_dir   <= dir;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Hold at the last count instead of wrapping; the sequence ends here.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q       = w_q;
    assign ser_out = (r_dir == DIR_RIGHT) ? w_q[0] : w_q[WIDTH-1];
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Bench for serial_shift_unit: directed scenarios plus random traffic, all
// checked every cycle against a shifts-remaining behavioural model.
`timescale 1ns/1ns
module tb_serial_shift_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic         start;
    logic         dir;
    logic [W-1:0] par_in;
    logic         ser_in;
    logic [W-1:0] q;
    logic         ser_out;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    serial_shift_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .start   (start),
        .dir     (dir),
        .par_in  (par_in),
        .ser_in  (ser_in),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Model: register value, direction, shifts still owed, and a done flag.
    logic [W-1:0] m_q;
    logic         m_dir;
    int           m_left;
    logic         m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = '0; m_dir = 1'b0; m_left = 0; m_done = 1'b0;
        end else if (en) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_left > 0) begin
                if (m_dir) m_q = {ser_in, m_q[W-1:1]};
                else       m_q = {m_q[W-2:0], ser_in};
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end else if (load) begin
                m_q = par_in;
            end else if (start) begin
                m_dir  = dir;
                m_left = W;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model q", 16'(q), 16'(m_q));
        chk("model ser_out", 16'(ser_out), 16'(m_dir ? m_q[0] : m_q[W-1]));
        chk("model busy", 16'(busy), 16'((m_left > 0) || m_done));
        chk("model done", 16'(done), 16'(m_done));
    end

    task automatic step(input logic l, input logic s, input logic d,
                        input logic [W-1:0] p, input logic si, input logic e);
        load = l; start = s; dir = d; par_in = p; ser_in = si; en = e;
        @(posedge clk); #1;
    endtask

    logic [W-1:0] seqv;
    logic [W-1:0] saved_q;

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; dir = 1'b0;
        par_in = '0; ser_in = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset q", 16'(q), 16'h0);
        chk("reset busy", 16'(busy), 16'h0);
        chk("reset done", 16'(done), 16'h0);
        chk("reset ser_out", 16'(ser_out), 16'h0);
        rst = 1'b0;

        // Load A5, shift left with zeros: ser_out must replay A5 MSB first.
        step(1, 0, 0, 8'hA5, 0, 1);
        chk("load q", 16'(q), 16'hA5);
        step(0, 1, 0, 8'h00, 0, 1);
        chk("start busy", 16'(busy), 16'h1);
        seqv = '0;
        for (int i = 0; i < W; i++) begin
            seqv = {seqv[W-2:0], ser_out};
            if (i == W - 1) chk("done early", 16'(done), 16'h0);
            step(0, 0, 0, 8'h00, 0, 1);
        end
        chk("left ser_out seq", 16'(seqv), 16'hA5);
        chk("left done", 16'(done), 16'h1);
        chk("left q", 16'(q), 16'h00);
        step(0, 0, 0, 8'h00, 0, 1);
        chk("done pulse end", 16'(done), 16'h0);
        chk("busy end", 16'(busy), 16'h0);

        // Right shift filling with ones.
        step(1, 0, 0, 8'h00, 0, 1);
        step(0, 1, 1, 8'h00, 1, 1);
        for (int i = 0; i < W; i++) step(0, 0, 0, 8'h00, 1, 1);
        chk("right done", 16'(done), 16'h1);
        chk("right q", 16'(q), 16'hFF);
        step(0, 0, 0, 8'h00, 0, 1);

        // Load wins over start.
        step(1, 1, 0, 8'h3C, 0, 1);
        chk("load+start q", 16'(q), 16'h3C);
        chk("load+start busy", 16'(busy), 16'h0);
        step(0, 0, 0, 8'h00, 0, 1);
        chk("load+start idle", 16'(busy), 16'h0);

        // Enable stall mid-shift.
        step(1, 0, 0, 8'hA5, 0, 1);
        step(0, 1, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1, 1);
        saved_q = q;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 8'h55, 0, 0);
            chk("stall q", 16'(q), 16'(saved_q));
            chk("stall busy", 16'(busy), 16'h1);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1, 1);
        chk("stall not done", 16'(done), 16'h0);
        step(0, 0, 0, 8'h00, 1, 1);
        chk("stall done", 16'(done), 16'h1);
        chk("stall q final", 16'(q), 16'hFF);
        step(0, 0, 0, 8'h00, 0, 1);

        // Busy lockout: load/start mid-sequence are ignored.
        step(1, 0, 0, 8'h0F, 0, 1);
        step(0, 1, 1, 8'h00, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 8'h00, 0, 1);
        step(1, 1, 0, 8'hFF, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 0, 1);
        chk("lockout done", 16'(done), 16'h1);
        chk("lockout q", 16'(q), 16'h00);
        step(0, 0, 0, 8'h00, 0, 1);

        // Asynchronous reset mid-shift, then a clean sequence.
        step(1, 0, 0, 8'hA5, 0, 1);
        step(0, 1, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst q", 16'(q), 16'h0);
        chk("async rst busy", 16'(busy), 16'h0);
        chk("async rst done", 16'(done), 16'h0);
        chk("async rst ser_out", 16'(ser_out), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 0, 0, 8'h81, 0, 1);
        step(0, 1, 1, 8'h00, 0, 1);
        for (int i = 0; i < W; i++) step(0, 0, 0, 8'h00, 0, 1);
        chk("post rst done", 16'(done), 16'h1);
        chk("post rst q", 16'(q), 16'h00);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step(logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 1)), W'($urandom), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 4) != 0));
            rst = 1'b0;
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Universal WIDTH-bit shift register with parallel load, serial in/out and a shift-sequence controller that performs exactly WIDTH shifts per start command and then pulses done. It is the synchronous stage directly downstream of the level-sensitive D latch: its storage is edge-triggered master-slave flip-flops built from latch pairs, and it serialises a parallel word for the next stage.

## Interface
- WIDTH, 8, data width in bits; legal range 2..16
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  clock enable; 0 freezes all state, including counter, FSM and register
- load  input  1  parallel-load request, honoured only in IDLE
- start  input  1  begin a WIDTH-shift sequence, honoured only in IDLE
- dir  input  1  shift direction, sampled at start: 0 = left (toward MSB), 1 = right (toward LSB)
- par_in  input  WIDTH  parallel load data
- ser_in  input  1  serial data shifted into the vacated end
- q  output  WIDTH  register contents
- ser_out  output  1  outgoing bit: q[WIDTH-1] if dir_r=0, q[0] if dir_r=1
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse in DONE

## Operation
- FSM states: IDLE, SHIFT, DONE. Every transition requires en=1 at the rising edge.
- IDLE:
  - load=1: q <= par_in; stay IDLE. load has priority over start.
  - else start=1: dir_r <= dir, cnt <= 0, go SHIFT; q unchanged.
- SHIFT, each enabled edge:
  - Left: q <= {q[WIDTH-2:0], ser_in}. Right: q <= {ser_in, q[WIDTH-1:1]}.
  - cnt <= cnt+1. On the edge where cnt == WIDTH-1, go DONE.
- DONE: done=1, q holds; next enabled edge returns to IDLE.
- load and start are ignored while busy; they are not queued.
- cnt is ceil(log2(WIDTH)) bits and never wraps, because the sequence terminates at WIDTH-1.
- en=0 in any state: nothing changes and done, if high, stays high until the next enabled edge.
- ser_out is combinational from q and dir_r.
- Reset, asynchronous at any time including mid-sequence: q=0, cnt=0, dir_r=0, state IDLE, busy=0, done=0, ser_out=0. The sequence is abandoned. The first edge after rst deasserts behaves as IDLE.

## Timing
- Single clock domain. All state updates on the rising edge of clk, with zero modelled delay at register level. timescale is 1ns/1ns.
- Start sampled at edge t:
  - busy=1 after edge t.
  - Shifts occur on enabled edges t+1 .. t+WIDTH.
  - done=1 for the cycle after edge t+WIDTH.
  - busy=0 after edge t+WIDTH+1.
- Latency from start to done is WIDTH+1 enabled cycles. Each en=0 cycle extends it by one.
- Load takes effect after one edge.
- ser_out during SHIFT shows the bit that leaves on the next shift.
- The earliest next start is sampled on edge t+WIDTH+2.

## Structure
- Package serial_shift_pkg holds:
  - enum state_t {IDLE, SHIFT, DONE}
  - constants DIR_LEFT=0 and DIR_RIGHT=1
  - function cnt_width(WIDTH)
- Sub-module ms_dff: master-slave D flip-flop with enable and asynchronous active-high reset.
  - Structure: master latch transparent on clk=0, slave latch transparent on clk=1, each latch a 2:1 mux with feedback.
  - Instantiated WIDTH times for q; FSM, cnt and dir_r may be behavioural.

## Test plan
- Reset: assert rst mid-SHIFT of WIDTH=8 -> q=8'h00, busy=0, done=0 immediately, without waiting for an edge. After release, start works normally.
- Load then left shift: load par_in=8'hA5, start dir=0, ser_in=0 -> ser_out sequence 1,0,1,0,0,1,0,1 and final q=8'h00. done pulses exactly one cycle, 9 edges after start.
- Right shift fill: load 8'h00, start dir=1, ser_in=1 throughout -> q=8'hFF at done. ser_out reads q[0] each cycle.
- Simultaneous load and start in IDLE with par_in=8'h3C -> q=8'h3C, state stays IDLE, busy=0.
- Enable stall: during SHIFT, hold en=0 for 5 cycles -> q, cnt and busy frozen. done arrives 5 cycles late and the shifted result is unchanged.
- Busy lockout: pulse load with par_in=8'hFF and start mid-SHIFT -> both ignored; the sequence completes with the expected data.
